stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter WRAP_MINUTES, default 60, meaning the minute modulus; legal range 1..100.
REQ-002 Port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset: one clock; reset is asynchronous and active-high.
REQ-004 Port second_tick  input  1  one-cycle pulse from the timer, once per elapsed second.
REQ-005 Port start_stop  input  1  debounced start/stop button level.
REQ-006 Port clear  input  1  debounced clear request; active while high.
REQ-007 Port timer_enable  output  1  enable to the upstream timer.
REQ-008 Port timer_clear  output  1  one-cycle pulse that restarts the upstream timer's cycle count.
REQ-009 Port sec_ones  output  4  BCD seconds units, 0..9.
REQ-010 Port sec_tens  output  3  BCD seconds tens, 0..5.
REQ-011 Port min_ones  output  4  BCD minutes units, 0..9.
REQ-012 Port min_tens  output  4  BCD minutes tens, 0..9.
REQ-013 Port running  output  1  high when the FSM is in RUNNING.
REQ-014 Port rollover  output  1  one-cycle pulse on wrap to 00:00.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUNNING, PAUSED.
REQ-016 start_stop SHALL be rising-edge detected internally with a registered previous value; a held level SHALL count as one press.
REQ-017 Press transitions: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING; each takes effect at the edge that samples the press.
REQ-018 clear high in any state SHALL force IDLE, zero all digits at the next edge, and assert timer_clear for exactly that one cycle.
REQ-019 clear SHALL take priority over a simultaneous press and over a simultaneous second_tick; the tick is dropped.
REQ-020 timer_enable and running SHALL be decoded from the registered state only (RUNNING -> 1), with no combinational path from inputs.
REQ-021 A second_tick sampled while the state register is RUNNING SHALL advance the time by one second at that edge, so the new value is visible one cycle after the tick.
REQ-022 second_tick in IDLE or PAUSED SHALL be ignored; the digits hold.
REQ-023 A tick and a press together in RUNNING SHALL count the tick and move to PAUSED.
REQ-024 Carry chain: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into the minutes; minutes count 0..WRAP_MINUTES-1 in BCD.
REQ-025 At (WRAP_MINUTES-1):59 a counted tick SHALL yield 00:00, pulse rollover for one cycle, and remain RUNNING.
REQ-026 Leaving PAUSED for RUNNING SHALL NOT pulse timer_clear, so the partial second is preserved.

Reset
REQ-027 While rst is high the block SHALL hold: state IDLE, all digits 0, timer_enable 0, timer_clear 0, running 0, rollover 0, and edge-detect register 0.
REQ-028 Deasserting rst while start_stop is high SHALL NOT register a press until start_stop falls and rises again.

Structure
REQ-029 Package stopwatch_pkg SHALL hold the state enum type stopwatch_state_t and the BCD width constants.
REQ-030 Sub-module bcd_digit_counter SHALL implement one digit, with parameter MODULUS, inputs inc and clr, and outputs digit and carry; the block SHALL instantiate it four times.

Verification
REQ-031 Bench SHALL cover these scenarios:
- Reset, then 5 ticks in IDLE -> digits stay 00:00 and timer_enable=0.
- Press, then 61 ticks -> 01:01, running=1, timer_enable=1.
- Press to pause, 3 ticks, press again, 1 tick -> count advances by exactly 1.
- WRAP_MINUTES=60: preload to 59:59 via ticks, then 1 tick -> 00:00, rollover high for 1 cycle, still RUNNING.
- clear and second_tick in the same cycle at 00:07 -> 00:00, IDLE, timer_clear high for 1 cycle.
- rst asserted mid-count at 02:30 with start_stop held high -> 00:00 immediately; no start after release until start_stop rises again.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state type and BCD digit widths for the stopwatch
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} stopwatch_state_t;
    localparam int SEC_ONES_W = 4;
    localparam int SEC_TENS_W = 3;
    localparam int MIN_ONES_W = 4;
    localparam int MIN_TENS_W = 4;
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit counting 0..MODULUS-1, carry on wrap
module bcd_digit_counter #(
    parameter int MODULUS = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] digit,
    output logic         carry
);
    logic [W-1:0] digit_q, digit_d;
    assign carry = inc && digit_q == W'(MODULUS - 1);
    assign digit_d = (clr || carry) ? '0 : inc ? digit_q + 1'b1 : digit_q;
    assign digit = digit_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) digit_q <= '0;
        else digit_q <= digit_d;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/clear FSM driving a BCD mm:ss counter with wrap
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int WRAP_MINUTES = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  second_tick,
    input  logic                  start_stop,
    input  logic                  clear,
    output logic                  timer_enable,
    output logic                  timer_clear,
    output logic [SEC_ONES_W-1:0] sec_ones,
    output logic [SEC_TENS_W-1:0] sec_tens,
    output logic [MIN_ONES_W-1:0] min_ones,
    output logic [MIN_TENS_W-1:0] min_tens,
    output logic                  running,
    output logic                  rollover
);
    localparam logic [MIN_TENS_W-1:0] MAX_T = MIN_TENS_W'((WRAP_MINUTES - 1) / 10);
    localparam logic [MIN_ONES_W-1:0] MAX_O = MIN_ONES_W'((WRAP_MINUTES - 1) % 10);
    stopwatch_state_t state_q, state_d;
    logic ss_q, armed_q, timer_clear_q, rollover_q;
    logic press, tick_en, carry_so, carry_st, carry_mo, carry_mt, wrap, min_clr;
    // armed_q blocks a press from a button already held when reset was released
    assign press = start_stop & ~ss_q & armed_q;
    assign tick_en = second_tick & (state_q == RUNNING) & ~clear;
    assign wrap = (carry_st & min_tens == MAX_T & min_ones == MAX_O) | carry_mt;
    assign min_clr = clear | wrap;
    always_comb begin
        state_d = state_q;
        state_d = clear ? IDLE : !press ? state_q : state_q == RUNNING ? PAUSED : RUNNING;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q       <= IDLE;
            ss_q          <= 1'b0;
            armed_q       <= 1'b0;
            timer_clear_q <= 1'b0;
            rollover_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ss_q          <= start_stop;
            armed_q       <= armed_q | ~start_stop;
            timer_clear_q <= clear;
            rollover_q    <= wrap;
        end
    assign running = state_q == RUNNING;
    assign timer_enable = state_q == RUNNING;
    assign timer_clear = timer_clear_q;
    assign rollover = rollover_q;
    bcd_digit_counter #(.MODULUS(10), .W(SEC_ONES_W)) u_so (
        .clk(clk), .rst(rst), .inc(tick_en), .clr(clear), .digit(sec_ones), .carry(carry_so));
    bcd_digit_counter #(.MODULUS(6), .W(SEC_TENS_W)) u_st (
        .clk(clk), .rst(rst), .inc(carry_so), .clr(clear), .digit(sec_tens), .carry(carry_st));
    bcd_digit_counter #(.MODULUS(10), .W(MIN_ONES_W)) u_mo (
        .clk(clk), .rst(rst), .inc(carry_st), .clr(min_clr), .digit(min_ones), .carry(carry_mo));
    bcd_digit_counter #(.MODULUS(10), .W(MIN_TENS_W)) u_mt (
        .clk(clk), .rst(rst), .inc(carry_mo), .clr(min_clr), .digit(min_tens), .carry(carry_mt));
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios checked against a seconds-count model via a scoreboard
module tb_stopwatch_ctrl;
    localparam int WRAP = 60;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
    typedef struct {string tag; logic [18:0] v;} exp_t;
    logic clk = 1'b0, rst, second_tick, start_stop, clear;
    logic timer_enable, timer_clear, running, rollover;
    logic [3:0] sec_ones, min_ones, min_tens;
    logic [2:0] sec_tens;
    logic [18:0] obs;
    exp_t sb[$];
    int checks = 0, errors = 0;
    int secs_m, st_m;
    bit ss_prev_m, armed_m;

    stopwatch_ctrl #(.WRAP_MINUTES(WRAP)) dut (
        .clk(clk), .rst(rst), .second_tick(second_tick), .start_stop(start_stop),
        .clear(clear), .timer_enable(timer_enable), .timer_clear(timer_clear),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
        .min_tens(min_tens), .running(running), .rollover(rollover));

    always #5 clk = ~clk;
    assign obs = {min_tens, min_ones, sec_tens, sec_ones, running, timer_enable, timer_clear, rollover};

    function automatic logic [18:0] pack(int s, bit run, bit tc, bit ro);
        int m = s / 60;
        int sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 3'(sc / 10), 4'(sc % 10), run, run, tc, ro};
    endfunction

    task automatic check_out();
        exp_t e = sb.pop_front();
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", e.tag, obs, e.v);
        end
    endtask

    task automatic drive(input bit tk, input bit ss, input bit cl, input string tag);
        bit pr, cnt, wr;
        pr = ss && !ss_prev_m && armed_m;
        cnt = tk && st_m == M_RUN && !cl;
        wr = cnt && secs_m == WRAP * 60 - 1;
        secs_m = cl ? 0 : cnt ? (secs_m + 1) % (WRAP * 60) : secs_m;
        st_m = cl ? M_IDLE : pr ? (st_m == M_RUN ? M_PAUSE : M_RUN) : st_m;
        ss_prev_m = ss;
        armed_m = armed_m | !ss;
        sb.push_back('{tag, pack(secs_m, st_m == M_RUN, cl, wr)});
        second_tick = tk;
        start_stop = ss;
        clear = cl;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset(input bit ss, input string tag);
        second_tick = 1'b0;
        clear = 1'b0;
        start_stop = ss;
        rst = 1'b1;
        secs_m = 0;
        st_m = M_IDLE;
        ss_prev_m = 1'b0;
        armed_m = 1'b0;
        sb.push_back('{tag, pack(0, 1'b0, 1'b0, 1'b0)});
        #1;
        check_out();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic press(input string tag);
        drive(1'b0, 1'b1, 1'b0, tag);
        drive(1'b0, 1'b0, 1'b0, {tag, "_rel"});
    endtask

    initial begin
        rst = 1'b1;
        second_tick = 1'b0;
        start_stop = 1'b0;
        clear = 1'b0;
        do_reset(1'b0, "reset");
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, "idle_tick");
        press("start");
        for (int i = 0; i < 61; i++) drive(1'b1, 1'b0, 1'b0, "run_61");
        press("pause");
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, "paused_tick");
        press("resume");
        drive(1'b1, 1'b0, 1'b0, "resume_tick");
        drive(1'b1, 1'b1, 1'b0, "tick_and_press");
        drive(1'b1, 1'b0, 1'b0, "paused_after_tp");
        drive(1'b0, 1'b1, 1'b1, "clear_vs_press");
        drive(1'b0, 1'b0, 1'b0, "after_clear");
        press("start2");
        for (int i = 0; i < WRAP * 60 - 1; i++) drive(1'b1, 1'b0, 1'b0, "preload");
        drive(1'b1, 1'b0, 1'b0, "wrap");
        drive(1'b0, 1'b0, 1'b0, "after_wrap");
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, "to_0007");
        drive(1'b1, 1'b0, 1'b1, "clear_tick");
        drive(1'b0, 1'b0, 1'b0, "tclr_pulse_end");
        drive(1'b1, 1'b0, 1'b0, "idle_after_clear");
        press("start3");
        for (int i = 0; i < 150; i++) drive(1'b1, 1'b0, 1'b0, "to_0230");
        do_reset(1'b1, "reset_held_ss");
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, "no_start_held");
        drive(1'b1, 1'b1, 1'b0, "held_tick");
        drive(1'b0, 1'b0, 1'b0, "ss_low");
        drive(1'b0, 1'b1, 1'b0, "restart");
        drive(1'b1, 1'b1, 1'b0, "restart_tick");
        drive(1'b0, 1'b0, 1'b0, "final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
